sb_rx_decoder: RTL and testbench
================================

SB_RX_DECODER -- requirements
Module: sb_rx_decoder

Interface
REQ-001 Parameter MAX_PAYLOAD, default 64: maximum de-stuffed payload bytes per AT frame, excluding the CRC bytes.
REQ-002 sb_clk  input  1  sideband bit clock; one UART bit per cycle.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 sbrx  input  1  sideband receive line; idles high.
REQ-005 payload_byte  output  8  de-stuffed payload byte.
REQ-006 payload_valid  output  1  payload_byte is valid this cycle.
REQ-007 frame_type  output  1  0 = AT command (STX_CMD), 1 = AT response (STX_RSP); stable from frame_start until the next frame_start.
REQ-008 frame_start  output  1  one-cycle pulse when an STX is accepted.
REQ-009 frame_done  output  1  one-cycle pulse on a well-formed DLE ETX close.
REQ-010 crc_ok  output  1  CRC result; valid only while frame_done is high.
REQ-011 frame_err  output  1  one-cycle pulse when an open AT frame is aborted.
REQ-012 lt_valid  output  1  one-cycle pulse when a valid LT transaction is received.
REQ-013 lt_lse  output  8  LSE byte; valid with lt_valid.
REQ-014 lt_err  output  1  one-cycle pulse when CLSE is not the bitwise complement of LSE.

Function
REQ-015 UART: a 0 on sbrx in idle is the start bit; the next 8 cycles are data, LSB first; the following cycle is the stop bit.
REQ-016 Byte strobe: an internal one-cycle strobe fires the cycle after the stop bit when the stop bit is 1; the next start bit may begin that same cycle.
REQ-017 Framing error: a stop bit of 0 gives no strobe, pulses frame_err if an AT frame is open, and returns the FSM to IDLE.
REQ-018 FSM states: IDLE, GOT_DLE, BODY, BODY_DLE, LT_CLSE; the FSM advances only on a byte strobe.
REQ-019 IDLE: DLE -> GOT_DLE; any other byte -> stay in IDLE.
REQ-020 GOT_DLE: STX_CMD/STX_RSP -> BODY, pulse frame_start, set frame_type, init CRC with the STX byte, clear the count.
  - DLE -> stay in GOT_DLE.
  - Any byte with bit7 = 1 -> LT_CLSE, capture it as LSE.
  - Any other byte -> IDLE.
REQ-021 LT_CLSE: byte == ~LSE -> lt_valid with lt_lse; otherwise lt_err; both cases -> IDLE.
REQ-022 BODY: DLE -> BODY_DLE; any other byte is a body byte.
REQ-023 BODY_DLE: DLE -> body byte 0xFE, return to BODY.
  - ETX -> close the frame, go to IDLE.
  - Any other byte -> frame_err, go to IDLE.
REQ-024 Body bytes pass through a 2-deep holding line; a byte is emitted on payload_byte/payload_valid only when a third body byte arrives.
  - Emission is registered, one cycle after that strobe.
  - The two bytes still held at ETX are the received CRC, high byte first.
REQ-025 CRC: CRC-16, poly 0x8005, init 0xFFFF, no reflection, no final XOR, computed over STX plus the de-stuffed payload.
REQ-026 Close with fewer than 2 body bytes -> frame_err, no frame_done.
  - Otherwise frame_done, with crc_ok = (computed == received).
  - crc_ok is asserted in the cycle after the last payload_valid, at the earliest.
REQ-027 The body-byte count saturates at MAX_PAYLOAD+2.
  - Reaching MAX_PAYLOAD+3 -> frame_err, IDLE; later bytes are discarded until the next DLE.
REQ-028 frame_done, frame_err, lt_valid and lt_err are mutually exclusive in any cycle.

Reset
REQ-029 rst = 0 on a sb_clk edge sets the FSM to IDLE, clears the UART deserializer, holding line, count and CRC, and drives every output to 0.
REQ-030 Reset mid-frame or mid-byte discards all partial state; no frame_err is emitted for the abandoned frame.
REQ-031 After rst returns to 1, the block requires a fresh idle-to-start transition before decoding.

Configuration
REQ-032 With SB_RX_CRC_CHECK_EN defined: the CRC engine is present and crc_ok reflects the comparison in REQ-026.
REQ-033 Without SB_RX_CRC_CHECK_EN: no CRC logic is built, crc_ok is 1 whenever frame_done is high, and the two trailing bytes are still stripped.

Structure
REQ-034 Shared package sb_pkg holds:
  - constants DLE = 8'hFE, STX_CMD = 8'h05, STX_RSP = 8'h45, ETX = 8'h40;
  - the FSM state enum;
  - the CRC-16 byte-update function.
REQ-035 Sub-module sb_uart_rx implements REQ-015..017 and outputs byte, strobe and framing error; sb_rx_decoder holds the FSM, holding line, count and CRC.

Verification
REQ-036 Send FE 05 11 22 33 CRC_H CRC_L FE 40 with the correct CRC -> frame_start, frame_type = 0, payload 11/22/33, frame_done with crc_ok = 1, no frame_err.
REQ-037 Send FE 45 FE FE 7A CRC FE 40 -> frame_type = 1, payload FE then 7A, crc_ok = 1.
  - Same frame with CRC_L XOR 01 -> crc_ok = 0 (with SB_RX_CRC_CHECK_EN); crc_ok = 1 (without it).
REQ-038 Send FE 93 6C -> lt_valid, lt_lse = 93.
  - Send FE 93 6D -> lt_err, no lt_valid.
REQ-039 Send FE 05 followed by 67 bytes with MAX_PAYLOAD = 64 -> frame_err on the 67th byte strobe, then IDLE.
  - A following valid frame decodes correctly.
REQ-040 Force the stop bit of the 2nd payload byte to 0 -> frame_err, no frame_done.
  - Assert rst = 0 for 3 cycles mid-frame -> all outputs 0, no frame_err, and the next frame decodes normally.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared sideband constants, decoder FSM state encoding and the CRC-16 byte update.
// The CRC helper is only referenced when SB_RX_CRC_CHECK_EN is defined.
package sb_pkg;

   localparam logic [7:0]  DLE      = 8'hFE;
   localparam logic [7:0]  STX_CMD  = 8'h05;
   localparam logic [7:0]  STX_RSP  = 8'h45;
   localparam logic [7:0]  ETX      = 8'h40;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'h8005;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GOT_DLE,
      ST_BODY,
      ST_BODY_DLE,
      ST_LT_CLSE
   } sb_state_e;

   typedef enum logic [1:0] {
      UART_IDLE,
      UART_DATA,
      UART_STOP
   } sb_uart_state_e;

   // MSB-first, non-reflected CRC-16 over one byte.
   function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         fb = c[15] ^ data[i];
         c  = {c[14:0], 1'b0};
         if (fb) begin
            c = c ^ CRC_POLY;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/sb_rx_decoder_if.sv
// Sideband receive line plus decoded frame / link-training outputs.
// master = decoder side, slave = consumer side that drives sbrx.
interface sb_rx_decoder_if;

   logic       sbrx;
   logic [7:0] payload_byte;
   logic       payload_valid;
   logic       frame_type;
   logic       frame_start;
   logic       frame_done;
   logic       crc_ok;
   logic       frame_err;
   logic       lt_valid;
   logic [7:0] lt_lse;
   logic       lt_err;

   modport master (
      input  sbrx,
      output payload_byte, payload_valid, frame_type, frame_start, frame_done,
             crc_ok, frame_err, lt_valid, lt_lse, lt_err
   );

   modport slave (
      output sbrx,
      input  payload_byte, payload_valid, frame_type, frame_start, frame_done,
             crc_ok, frame_err, lt_valid, lt_lse, lt_err
   );

endinterface

// File: rtl/sb_uart_rx.sv
// One-cycle-per-bit UART deserializer: start bit, 8 data bits LSB first, stop bit.
// Emits a byte strobe (good stop) or framing error (bad stop) the cycle after the stop bit.
module sb_uart_rx
   import sb_pkg::*;
(
   input  logic       sb_clk,
   input  logic       rst,
   input  logic       sbrx,
   output logic [7:0] rx_byte,
   output logic       rx_strobe,
   output logic       rx_ferr
);

   sb_uart_state_e state_q, state_d;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic [7:0]     byte_q, byte_d;
   logic           armed_q, armed_d;
   logic           strobe_q, strobe_d;
   logic           ferr_q, ferr_d;

   // armed_q demands a high line before a start bit is accepted, so a line held low
   // through reset or after a broken stop bit is never mistaken for a start.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      byte_d    = byte_q;
      armed_d   = armed_q;
      strobe_d  = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         UART_IDLE: begin
            if (sbrx) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d   = UART_DATA;
               bit_cnt_d = 3'd0;
            end
         end
         UART_DATA: begin
            shift_d   = {sbrx, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               state_d = UART_STOP;
            end
         end
         UART_STOP: begin
            state_d = UART_IDLE;
            if (sbrx) begin
               strobe_d = 1'b1;
               byte_d   = shift_q;
            end else begin
               ferr_d  = 1'b1;
               armed_d = 1'b0;
            end
         end
         default: state_d = UART_IDLE;
      endcase
   end

   always_ff @(posedge sb_clk) begin
      if (!rst) begin
         state_q   <= UART_IDLE;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'h00;
         byte_q    <= 8'h00;
         armed_q   <= 1'b0;
         strobe_q  <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         byte_q    <= byte_d;
         armed_q   <= armed_d;
         strobe_q  <= strobe_d;
         ferr_q    <= ferr_d;
      end
   end

   assign rx_byte   = byte_q;
   assign rx_strobe = strobe_q;
   assign rx_ferr   = ferr_q;

endmodule

// File: rtl/sb_rx_decoder.sv
// Sideband AT-frame / link-training decoder: DLE de-stuffing, 2-byte CRC holding line, CRC-16 check.
// Define SB_RX_CRC_CHECK_EN to build the CRC engine; otherwise crc_ok is forced high at frame_done.
module sb_rx_decoder
   import sb_pkg::*;
#(
   parameter int MAX_PAYLOAD = 64
)(
   input  logic             sb_clk,
   input  logic             rst,
   sb_rx_decoder_if.master  bus
);

   localparam int              CNT_W   = $clog2(MAX_PAYLOAD + 3);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PAYLOAD + 2);

   logic [7:0] rx_byte;
   logic       rx_strobe;
   logic       rx_ferr;

   sb_uart_rx u_uart (
      .sb_clk    (sb_clk),
      .rst       (rst),
      .sbrx      (bus.sbrx),
      .rx_byte   (rx_byte),
      .rx_strobe (rx_strobe),
      .rx_ferr   (rx_ferr)
   );

   sb_state_e        state_q, state_d;
   logic [7:0]       lse_q, lse_d;
   logic [7:0]       hold0_q, hold0_d;
   logic [7:0]       hold1_q, hold1_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       payload_byte_q, payload_byte_d;
   logic             payload_valid_q, payload_valid_d;
   logic             frame_type_q, frame_type_d;
   logic             frame_start_q, frame_start_d;
   logic             frame_done_q, frame_done_d;
   logic             crc_ok_q, crc_ok_d;
   logic             frame_err_q, frame_err_d;
   logic             lt_valid_q, lt_valid_d;
   logic [7:0]       lt_lse_q, lt_lse_d;
   logic             lt_err_q, lt_err_d;
   logic             body_take;
   logic [7:0]       body_val;
`ifdef SB_RX_CRC_CHECK_EN
   logic [15:0]      crc_q, crc_d;
`endif

   always_comb begin
      state_d         = state_q;
      lse_d           = lse_q;
      hold0_d         = hold0_q;
      hold1_d         = hold1_q;
      count_d         = count_q;
      payload_byte_d  = payload_byte_q;
      payload_valid_d = 1'b0;
      frame_type_d    = frame_type_q;
      frame_start_d   = 1'b0;
      frame_done_d    = 1'b0;
      crc_ok_d        = 1'b0;
      frame_err_d     = 1'b0;
      lt_valid_d      = 1'b0;
      lt_lse_d        = lt_lse_q;
      lt_err_d        = 1'b0;
      body_take       = 1'b0;
      body_val        = rx_byte;
`ifdef SB_RX_CRC_CHECK_EN
      crc_d           = crc_q;
`endif
      if (rx_ferr) begin
         if (state_q == ST_BODY || state_q == ST_BODY_DLE) begin
            frame_err_d = 1'b1;
         end
         state_d = ST_IDLE;
      end else if (rx_strobe) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_byte == DLE) begin
                  state_d = ST_GOT_DLE;
               end
            end
            ST_GOT_DLE: begin
               if (rx_byte == DLE) begin
                  state_d = ST_GOT_DLE;
               end else if (rx_byte == STX_CMD || rx_byte == STX_RSP) begin
                  state_d       = ST_BODY;
                  frame_start_d = 1'b1;
                  frame_type_d  = (rx_byte == STX_RSP);
                  count_d       = '0;
`ifdef SB_RX_CRC_CHECK_EN
                  crc_d         = crc16_update(CRC_INIT, rx_byte);
`endif
               end else if (rx_byte[7]) begin
                  state_d = ST_LT_CLSE;
                  lse_d   = rx_byte;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LT_CLSE: begin
               state_d = ST_IDLE;
               if (rx_byte == ~lse_q) begin
                  lt_valid_d = 1'b1;
                  lt_lse_d   = lse_q;
               end else begin
                  lt_err_d = 1'b1;
               end
            end
            ST_BODY: begin
               if (rx_byte == DLE) begin
                  state_d = ST_BODY_DLE;
               end else begin
                  body_take = 1'b1;
               end
            end
            ST_BODY_DLE: begin
               if (rx_byte == DLE) begin
                  state_d   = ST_BODY;
                  body_take = 1'b1;
                  body_val  = DLE;
               end else if (rx_byte == ETX) begin
                  state_d = ST_IDLE;
                  if (count_q < CNT_W'(2)) begin
                     frame_err_d = 1'b1;
                  end else begin
                     frame_done_d = 1'b1;
`ifdef SB_RX_CRC_CHECK_EN
                     crc_ok_d     = (crc_q == {hold0_q, hold1_q});
`else
                     crc_ok_d     = 1'b1;
`endif
                  end
               end else begin
                  state_d     = ST_IDLE;
                  frame_err_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         // The two most recent body bytes stay held back so the trailing CRC is never emitted.
         if (body_take) begin
            if (count_q == CNT_MAX) begin
               frame_err_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               count_d = count_q + CNT_W'(1);
               hold0_d = hold1_q;
               hold1_d = body_val;
               if (count_q >= CNT_W'(2)) begin
                  payload_byte_d  = hold0_q;
                  payload_valid_d = 1'b1;
`ifdef SB_RX_CRC_CHECK_EN
                  crc_d           = crc16_update(crc_q, hold0_q);
`endif
               end
            end
         end
      end
   end

   always_ff @(posedge sb_clk) begin
      if (!rst) begin
         state_q         <= ST_IDLE;
         lse_q           <= 8'h00;
         hold0_q         <= 8'h00;
         hold1_q         <= 8'h00;
         count_q         <= '0;
         payload_byte_q  <= 8'h00;
         payload_valid_q <= 1'b0;
         frame_type_q    <= 1'b0;
         frame_start_q   <= 1'b0;
         frame_done_q    <= 1'b0;
         crc_ok_q        <= 1'b0;
         frame_err_q     <= 1'b0;
         lt_valid_q      <= 1'b0;
         lt_lse_q        <= 8'h00;
         lt_err_q        <= 1'b0;
`ifdef SB_RX_CRC_CHECK_EN
         crc_q           <= 16'h0000;
`endif
      end else begin
         state_q         <= state_d;
         lse_q           <= lse_d;
         hold0_q         <= hold0_d;
         hold1_q         <= hold1_d;
         count_q         <= count_d;
         payload_byte_q  <= payload_byte_d;
         payload_valid_q <= payload_valid_d;
         frame_type_q    <= frame_type_d;
         frame_start_q   <= frame_start_d;
         frame_done_q    <= frame_done_d;
         crc_ok_q        <= crc_ok_d;
         frame_err_q     <= frame_err_d;
         lt_valid_q      <= lt_valid_d;
         lt_lse_q        <= lt_lse_d;
         lt_err_q        <= lt_err_d;
`ifdef SB_RX_CRC_CHECK_EN
         crc_q           <= crc_d;
`endif
      end
   end

   assign bus.payload_byte  = payload_byte_q;
   assign bus.payload_valid = payload_valid_q;
   assign bus.frame_type    = frame_type_q;
   assign bus.frame_start   = frame_start_q;
   assign bus.frame_done    = frame_done_q;
   assign bus.crc_ok        = crc_ok_q;
   assign bus.frame_err     = frame_err_q;
   assign bus.lt_valid      = lt_valid_q;
   assign bus.lt_lse        = lt_lse_q;
   assign bus.lt_err        = lt_err_q;

endmodule

// File: tb/tb_sb_rx_decoder.sv
// Scoreboard bench for sb_rx_decoder: drives UART bytes on sbrx, queues expected payload,
// and counts frame/link-training events seen by the negedge monitor.
module tb_sb_rx_decoder;

   localparam logic [7:0] T_DLE = 8'hFE;
   localparam logic [7:0] T_ETX = 8'h40;

   typedef logic [7:0] byte_list_t[$];

   logic sb_clk = 1'b0;
   logic rst    = 1'b0;
   always #5 sb_clk = ~sb_clk;

   sb_rx_decoder_if bus();

   sb_rx_decoder #(.MAX_PAYLOAD(64)) dut (
      .sb_clk (sb_clk),
      .rst    (rst),
      .bus    (bus)
   );

   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   int         n_start, n_done, n_ferr, n_ltv, n_lterr, n_events;
   logic       last_type, last_crc_ok;
   logic [7:0] last_lse;

   // Monitor: pops the scoreboard on each payload byte and tallies the pulse outputs.
   always @(negedge sb_clk) begin
      if (rst) begin
         if (bus.payload_valid) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("[TB] FAIL payload_unexpected got=%h exp=none", bus.payload_byte);
            end else begin
               mon_exp = exp_q.pop_front();
               if (bus.payload_byte !== mon_exp) begin
                  tests_failed++;
                  $display("[TB] FAIL payload_byte got=%h exp=%h", bus.payload_byte, mon_exp);
               end
            end
         end
         if (bus.frame_start) begin
            n_start++;
            last_type = bus.frame_type;
         end
         if (bus.frame_done) begin
            n_done++;
            last_crc_ok = bus.crc_ok;
         end
         if (bus.frame_err) n_ferr++;
         if (bus.lt_valid) begin
            n_ltv++;
            last_lse = bus.lt_lse;
         end
         if (bus.lt_err) n_lterr++;
         n_events = int'(bus.frame_done) + int'(bus.frame_err) + int'(bus.lt_valid) + int'(bus.lt_err);
         if (n_events > 0) begin
            tests_run++;
            if (n_events > 1) begin
               tests_failed++;
               $display("[TB] FAIL exclusive_pulses got=%0d exp=1", n_events);
            end
         end
      end
   end

   function automatic logic [15:0] tb_crc(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      for (int k = 0; k < 8; k++) begin
         if (r[15]) r = (r << 1) ^ 16'h8005;
         else       r = r << 1;
      end
      return r;
   endfunction

   task automatic uart_byte(input logic [7:0] b, input logic stop);
      @(negedge sb_clk) bus.sbrx = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge sb_clk) bus.sbrx = b[i];
      end
      @(negedge sb_clk) bus.sbrx = stop;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(negedge sb_clk) bus.sbrx = 1'b1;
      end
   endtask

   task automatic send_stuffed(input logic [7:0] b);
      if (b == T_DLE) uart_byte(T_DLE, 1'b1);
      uart_byte(b, 1'b1);
   endtask

   task automatic applyStimulus(input logic [7:0] stx, input byte_list_t pl, input logic [7:0] crc_xor);
      logic [15:0] crc;
      crc = tb_crc(16'hFFFF, stx);
      foreach (pl[i]) begin
         crc = tb_crc(crc, pl[i]);
         exp_q.push_back(pl[i]);
      end
      uart_byte(T_DLE, 1'b1);
      uart_byte(stx, 1'b1);
      foreach (pl[i]) send_stuffed(pl[i]);
      send_stuffed(crc[15:8]);
      send_stuffed(crc[7:0] ^ crc_xor);
      uart_byte(T_DLE, 1'b1);
      uart_byte(T_ETX, 1'b1);
   endtask

   task automatic clear_counts();
      n_start = 0; n_done = 0; n_ferr = 0; n_ltv = 0; n_lterr = 0;
      last_type = 1'bx; last_crc_ok = 1'bx; last_lse = 8'hxx;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.sbrx = 1'b1;
      repeat (3) @(negedge sb_clk);
      tests_run++;
      if ({bus.payload_byte, bus.payload_valid, bus.frame_type, bus.frame_start, bus.frame_done,
           bus.crc_ok, bus.frame_err, bus.lt_valid, bus.lt_lse, bus.lt_err} !== 26'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs got=%b exp=0", {bus.payload_valid, bus.frame_start,
                  bus.frame_done, bus.crc_ok, bus.frame_err, bus.lt_valid, bus.lt_err});
      end
      rst = 1'b1;
      idle_cycles(2);
   endtask

   task automatic test_cmd_frame();
      clear_counts();
      applyStimulus(8'h05, '{8'h11, 8'h22, 8'h33}, 8'h00);
      idle_cycles(4);
      tests_run++; if (n_start !== 1)     begin tests_failed++; $display("[TB] FAIL cmd_start got=%0d exp=1", n_start); end
      tests_run++; if (last_type !== 1'b0) begin tests_failed++; $display("[TB] FAIL cmd_type got=%b exp=0", last_type); end
      tests_run++; if (n_done !== 1)      begin tests_failed++; $display("[TB] FAIL cmd_done got=%0d exp=1", n_done); end
      tests_run++; if (last_crc_ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL cmd_crc_ok got=%b exp=1", last_crc_ok); end
      tests_run++; if (n_ferr !== 0)      begin tests_failed++; $display("[TB] FAIL cmd_ferr got=%0d exp=0", n_ferr); end
      tests_run++; if (exp_q.size() !== 0) begin tests_failed++; $display("[TB] FAIL cmd_payload_left got=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_rsp_frame();
      logic exp_bad;
`ifdef SB_RX_CRC_CHECK_EN
      exp_bad = 1'b0;
`else
      exp_bad = 1'b1;
`endif
      clear_counts();
      applyStimulus(8'h45, '{8'hFE, 8'h7A}, 8'h00);
      idle_cycles(4);
      tests_run++; if (last_type !== 1'b1) begin tests_failed++; $display("[TB] FAIL rsp_type got=%b exp=1", last_type); end
      tests_run++; if (bus.frame_type !== 1'b1) begin tests_failed++; $display("[TB] FAIL rsp_type_hold got=%b exp=1", bus.frame_type); end
      tests_run++; if (n_done !== 1 || last_crc_ok !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL rsp_done got=%0d/%b exp=1/1", n_done, last_crc_ok); end
      tests_run++; if (exp_q.size() !== 0) begin tests_failed++; $display("[TB] FAIL rsp_payload_left got=%0d exp=0", exp_q.size()); end
      clear_counts();
      applyStimulus(8'h45, '{8'hFE, 8'h7A}, 8'h01);
      idle_cycles(4);
      tests_run++; if (n_done !== 1 || last_crc_ok !== exp_bad) begin
         tests_failed++; $display("[TB] FAIL rsp_bad_crc got=%0d/%b exp=1/%b", n_done, last_crc_ok, exp_bad); end
   endtask

   task automatic test_short_close();
      clear_counts();
      applyStimulus(8'h05, '{}, 8'h00);
      idle_cycles(4);
      tests_run++; if (n_done !== 1 || last_crc_ok !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL empty_frame got=%0d/%b exp=1/1", n_done, last_crc_ok); end
      clear_counts();
      uart_byte(T_DLE, 1'b1); uart_byte(8'h05, 1'b1); uart_byte(8'h11, 1'b1);
      uart_byte(T_DLE, 1'b1); uart_byte(T_ETX, 1'b1);
      idle_cycles(4);
      tests_run++; if (n_ferr !== 1 || n_done !== 0) begin
         tests_failed++; $display("[TB] FAIL short_close got=%0d/%0d exp=1/0", n_ferr, n_done); end
   endtask

   task automatic test_lt();
      clear_counts();
      uart_byte(T_DLE, 1'b1); uart_byte(8'h93, 1'b1); uart_byte(8'h6C, 1'b1);
      idle_cycles(4);
      tests_run++; if (n_ltv !== 1 || last_lse !== 8'h93) begin
         tests_failed++; $display("[TB] FAIL lt_valid got=%0d/%h exp=1/93", n_ltv, last_lse); end
      tests_run++; if (n_lterr !== 0) begin tests_failed++; $display("[TB] FAIL lt_no_err got=%0d exp=0", n_lterr); end
      clear_counts();
      uart_byte(T_DLE, 1'b1); uart_byte(8'h93, 1'b1); uart_byte(8'h6D, 1'b1);
      idle_cycles(4);
      tests_run++; if (n_lterr !== 1 || n_ltv !== 0) begin
         tests_failed++; $display("[TB] FAIL lt_err got=%0d/%0d exp=1/0", n_lterr, n_ltv); end
   endtask

   task automatic test_overflow();
      logic [7:0] v;
      clear_counts();
      uart_byte(T_DLE, 1'b1); uart_byte(8'h05, 1'b1);
      for (int i = 0; i < 66; i++) begin
         v = 8'h10 + 8'(i);
         if (i < 64) exp_q.push_back(v);
         uart_byte(v, 1'b1);
      end
      idle_cycles(4);
      tests_run++; if (n_ferr !== 0) begin tests_failed++; $display("[TB] FAIL ovf_at_limit got=%0d exp=0", n_ferr); end
      uart_byte(8'h52, 1'b1);
      idle_cycles(4);
      tests_run++; if (n_ferr !== 1 || n_done !== 0) begin
         tests_failed++; $display("[TB] FAIL ovf_err got=%0d/%0d exp=1/0", n_ferr, n_done); end
      tests_run++; if (exp_q.size() !== 0) begin tests_failed++; $display("[TB] FAIL ovf_payload_left got=%0d exp=0", exp_q.size()); end
      uart_byte(8'h55, 1'b1);
      clear_counts();
      applyStimulus(8'h05, '{8'hA1, 8'hB2}, 8'h00);
      idle_cycles(4);
      tests_run++; if (n_done !== 1 || last_crc_ok !== 1'b1 || n_ferr !== 0) begin
         tests_failed++; $display("[TB] FAIL ovf_recover got=%0d/%b/%0d exp=1/1/0", n_done, last_crc_ok, n_ferr); end
   endtask

   task automatic test_stop_error();
      clear_counts();
      uart_byte(T_DLE, 1'b1); uart_byte(8'h05, 1'b1); uart_byte(8'hAA, 1'b1);
      uart_byte(8'hBB, 1'b0);
      idle_cycles(4);
      tests_run++; if (n_ferr !== 1 || n_done !== 0) begin
         tests_failed++; $display("[TB] FAIL stop_err got=%0d/%0d exp=1/0", n_ferr, n_done); end
   endtask

   task automatic test_mid_reset();
      clear_counts();
      uart_byte(T_DLE, 1'b1); uart_byte(8'h05, 1'b1);
      uart_byte(8'h11, 1'b1); uart_byte(8'h22, 1'b1);
      exp_q.push_back(8'h11);
      uart_byte(8'h33, 1'b1);
      @(negedge sb_clk) bus.sbrx = 1'b0;
      repeat (3) @(negedge sb_clk) bus.sbrx = 1'b1;
      rst = 1'b0;
      repeat (3) begin
         @(negedge sb_clk);
         tests_run++;
         if ({bus.payload_valid, bus.frame_start, bus.frame_done, bus.crc_ok, bus.frame_err,
              bus.lt_valid, bus.lt_err, bus.frame_type} !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_outputs got=%b exp=0", {bus.payload_valid, bus.frame_start,
                     bus.frame_done, bus.crc_ok, bus.frame_err, bus.lt_valid, bus.lt_err, bus.frame_type});
         end
      end
      rst = 1'b1;
      idle_cycles(2);
      tests_run++; if (n_ferr !== 0 || exp_q.size() !== 0) begin
         tests_failed++; $display("[TB] FAIL midrst_state got=%0d/%0d exp=0/0", n_ferr, exp_q.size()); end
      clear_counts();
      applyStimulus(8'h05, '{8'h01, 8'h02, 8'h03, 8'h04}, 8'h00);
      idle_cycles(4);
      tests_run++; if (n_done !== 1 || last_crc_ok !== 1'b1 || exp_q.size() !== 0) begin
         tests_failed++; $display("[TB] FAIL midrst_recover got=%0d/%b exp=1/1", n_done, last_crc_ok); end
   endtask

   task automatic test_back_to_back();
      clear_counts();
      applyStimulus(8'h05, '{8'h5A, 8'hC3, 8'h0F}, 8'h00);
      applyStimulus(8'h45, '{8'h77}, 8'h00);
      idle_cycles(4);
      tests_run++; if (n_start !== 2 || n_done !== 2 || last_crc_ok !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL b2b got=%0d/%0d/%b exp=2/2/1", n_start, n_done, last_crc_ok); end
      tests_run++; if (exp_q.size() !== 0 || last_type !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL b2b_tail got=%0d/%b exp=0/1", exp_q.size(), last_type); end
   endtask

   initial begin
      bus.sbrx = 1'b1;
      clear_counts();
      test_reset();
      test_cmd_frame();
      test_rsp_frame();
      test_short_close();
      test_lt();
      test_overflow();
      test_stop_error();
      test_mid_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
